// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl
// Purpose  : Multi-cycle control unit for the MIPS-subset core. Sequences a
//            shared datapath through FETCH, DECODE, EXEC, MEM_RD, MEM_WR and
//            WB, drives datapath strobes and mux selects, and stalls on the
//            memory-ready handshake.
// Options  : MC_PERF_CNT_EN - builds the cycle/retired-instruction counters;
//            when undefined the counter outputs are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             cmp_eq,
  input  logic             cmp_gtz,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             reg_write,
  output logic [2:0]       alu_control,
  output logic             alu_src,
  output logic [2:0]       ext_control,
  output logic [1:0]       reg_dst,
  output logic [2:0]       mem2reg,
  output logic [2:0]       npc_control,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM_RD = 3'd3,
    S_MEM_WR = 3'd4,
    S_WB     = 3'd5
  } state_t;

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_ori   = 6'b001101;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_lb    = 6'b100000;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_bgtz  = 6'b000111;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_lui   = 6'b001111;
  localparam logic [5:0] c_op_j     = 6'b000010;
  localparam logic [5:0] c_op_jal   = 6'b000011;
  localparam logic [5:0] c_op_bal   = 6'b110000;

  localparam logic [5:0] c_fn_add   = 6'b100000;
  localparam logic [5:0] c_fn_sub   = 6'b100010;
  localparam logic [5:0] c_fn_xor   = 6'b100110;
  localparam logic [5:0] c_fn_sll   = 6'b000000;
  localparam logic [5:0] c_fn_jr    = 6'b001000;
  localparam logic [5:0] c_fn_jalr  = 6'b001001;

  state_t r_state;
  state_t w_next;

  logic w_rtype;
  logic w_add, w_sub, w_xor, w_sll, w_jr, w_jalr;
  logic w_ori, w_lw, w_lb, w_sw, w_beq, w_bgtz, w_addi, w_lui, w_j, w_jal, w_bal;
  logic w_legal;
  logic [2:0] w_ext;
  logic [2:0] w_alu;
  logic       w_alu_src;

  // Instruction decode (opcode/funct are stable from DECODE onward)
  assign w_rtype = (opcode == c_op_rtype);
  assign w_add   = w_rtype && (funct == c_fn_add);
  assign w_sub   = w_rtype && (funct == c_fn_sub);
  assign w_xor   = w_rtype && (funct == c_fn_xor);
  assign w_sll   = w_rtype && (funct == c_fn_sll);
  assign w_jr    = w_rtype && (funct == c_fn_jr);
  assign w_jalr  = w_rtype && (funct == c_fn_jalr);
  assign w_ori   = (opcode == c_op_ori);
  assign w_lw    = (opcode == c_op_lw);
  assign w_lb    = (opcode == c_op_lb);
  assign w_sw    = (opcode == c_op_sw);
  assign w_beq   = (opcode == c_op_beq);
  assign w_bgtz  = (opcode == c_op_bgtz);
  assign w_addi  = (opcode == c_op_addi);
  assign w_lui   = (opcode == c_op_lui);
  assign w_j     = (opcode == c_op_j);
  assign w_jal   = (opcode == c_op_jal);
  assign w_bal   = (opcode == c_op_bal);

  assign w_legal = w_add | w_sub | w_xor | w_sll | w_jr | w_jalr | w_ori | w_lw |
                   w_lb | w_sw | w_beq | w_bgtz | w_addi | w_lui | w_j | w_jal | w_bal;

  assign w_alu_src = w_ori | w_addi | w_lui;

  // Immediate extension mode: lui shifts, signed-offset users sign-extend, ori zero-extends
  always_comb begin
    w_ext = 3'b000;
    if (w_lui) begin
      w_ext = 3'b010;
    end else if (w_addi | w_lw | w_lb | w_sw | w_beq | w_bgtz | w_bal) begin
      w_ext = 3'b001;
    end
  end

  // ALU operation select for the register/immediate ALU instructions
  always_comb begin
    w_alu = 3'b000;
    if (w_sub) begin
      w_alu = 3'b001;
    end else if (w_xor) begin
      w_alu = 3'b010;
    end else if (w_ori) begin
      w_alu = 3'b011;
    end else if (w_sll) begin
      w_alu = 3'b100;
    end
  end

  // State register; reset abandons any instruction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and datapath control outputs
  always_comb begin
    w_next      = S_FETCH;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    iord        = 1'b0;
    reg_write   = 1'b0;
    alu_control = 3'b000;
    alu_src     = 1'b0;
    ext_control = 3'b000;
    reg_dst     = 2'b00;
    mem2reg     = 3'b000;
    npc_control = 3'b000;
    illegal     = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read = 1'b1;
        // Reset holds the FSM here; the IR/PC loads must not fire while it is high
        ir_write = mem_ready & ~reset;
        pc_write = mem_ready & ~reset;
        w_next   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ext_control = w_ext;
        if (!w_legal) begin
          illegal = 1'b1;
          w_next  = S_FETCH;
        end else begin
          w_next  = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_lw | w_lb | w_sw) begin
          alu_control = 3'b000;
          alu_src     = 1'b1;
          ext_control = 3'b001;
          w_next      = w_sw ? S_MEM_WR : S_MEM_RD;
        end else if (w_beq) begin
          npc_control = 3'b001;
          pc_write    = cmp_eq;
          w_next      = S_FETCH;
        end else if (w_bgtz) begin
          npc_control = 3'b001;
          pc_write    = cmp_gtz;
          w_next      = S_FETCH;
        end else if (w_bal) begin
          npc_control = 3'b001;
          pc_write    = 1'b1;
          w_next      = S_WB;
        end else if (w_j | w_jal) begin
          npc_control = 3'b010;
          pc_write    = 1'b1;
          w_next      = w_jal ? S_WB : S_FETCH;
        end else if (w_jr | w_jalr) begin
          npc_control = 3'b100;
          pc_write    = 1'b1;
          w_next      = w_jalr ? S_WB : S_FETCH;
        end else begin
          alu_control = w_alu;
          alu_src     = w_alu_src;
          ext_control = w_ext;
          w_next      = S_WB;
        end
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        w_next   = mem_ready ? S_WB : S_MEM_RD;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        w_next    = mem_ready ? S_FETCH : S_MEM_WR;
      end
      S_WB: begin
        reg_write = 1'b1;
        if (w_jal | w_bal) begin
          reg_dst = 2'b10;
        end else if (w_rtype) begin
          reg_dst = 2'b01;
        end
        if (w_lw) begin
          mem2reg = 3'b001;
        end else if (w_lui) begin
          mem2reg = 3'b010;
        end else if (w_jal | w_jalr | w_bal) begin
          mem2reg = 3'b011;
        end else if (w_lb) begin
          mem2reg = 3'b100;
        end
        w_next = S_FETCH;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  assign state = r_state;

`ifdef MC_PERF_CNT_EN
  localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instr_cnt;
  logic             w_retire;

  assign w_retire = ((r_state == S_DECODE) || (r_state == S_EXEC) ||
                     (r_state == S_MEM_WR) || (r_state == S_WB)) && (w_next == S_FETCH);

  // Free-running cycle counter and retired-instruction counter, both wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + c_one;
      if (w_retire) begin
        r_instr_cnt <= r_instr_cnt + c_one;
      end
    end
  end

  assign cycle_cnt = r_cycle_cnt;
  assign instr_cnt = r_instr_cnt;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl
// Purpose  : Self-checking bench for mc_ctrl: instruction table, directed
//            stall/reset sequences and randomized instruction streams.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl;

  localparam int CW = 4;

  // Expected state sequences, first state in the low bits
  localparam logic [14:0] Q_ALU = {3'd0, 3'd5, 3'd2, 3'd1, 3'd0};
  localparam logic [14:0] Q_BR  = {3'd0, 3'd0, 3'd2, 3'd1, 3'd0};
  localparam logic [14:0] Q_LD  = {3'd5, 3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [14:0] Q_ST  = {3'd0, 3'd4, 3'd2, 3'd1, 3'd0};
  localparam logic [14:0] Q_ILL = {3'd0, 3'd0, 3'd0, 3'd1, 3'd0};

  // ext_control is a don't-care in DECODE
  localparam logic [24:0] MASK_ALL = 25'h1FFFFFF;
  localparam logic [24:0] MASK_DEC = 25'h1FFF1FF;

`ifdef MC_PERF_CNT_EN
  localparam logic [CW-1:0] WRAP_EXP = 4'd1;
`else
  localparam logic [CW-1:0] WRAP_EXP = 4'd0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    opcode, funct;
  logic          cmp_eq, cmp_gtz, mem_ready;
  logic          pc_write, ir_write, mem_read, mem_write, iord, reg_write;
  logic [2:0]    alu_control;
  logic          alu_src;
  logic [2:0]    ext_control;
  logic [1:0]    reg_dst;
  logic [2:0]    mem2reg, npc_control;
  logic          illegal;
  logic [2:0]    state;
  logic [CW-1:0] cycle_cnt, instr_cnt;

  always #5 clk = ~clk;

  mc_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .cmp_eq(cmp_eq), .cmp_gtz(cmp_gtz), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .iord(iord), .reg_write(reg_write),
    .alu_control(alu_control), .alu_src(alu_src), .ext_control(ext_control),
    .reg_dst(reg_dst), .mem2reg(mem2reg), .npc_control(npc_control),
    .illegal(illegal), .state(state), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        eq;
    logic        gtz;
    logic [2:0]  alu;
    logic        src;
    logic [2:0]  ext;
    logic [1:0]  dst;
    logic [2:0]  m2r;
    int          n;
    logic [14:0] seq;
  } row_t;

  row_t tbl[$];
  bit   rdy_q[$];
  bit   rnd = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   m_cyc = 0;
  int   m_ret = 0;

  task automatic add_row(input string nm, input logic [5:0] op, input logic [5:0] fn,
                         input logic eq, input logic gtz, input logic [2:0] alu,
                         input logic src, input logic [2:0] ext, input logic [1:0] dst,
                         input logic [2:0] m2r, input int n, input logic [14:0] seq);
    row_t r;
    r.name = nm; r.op = op; r.fn = fn; r.eq = eq; r.gtz = gtz; r.alu = alu;
    r.src = src; r.ext = ext; r.dst = dst; r.m2r = m2r; r.n = n; r.seq = seq;
    tbl.push_back(r);
  endtask

  function automatic int find(input string nm);
    for (int i = 0; i < tbl.size(); i++) if (tbl[i].name == nm) return i;
    return 0;
  endfunction

  function automatic logic [CW-1:0] exp_cc();
`ifdef MC_PERF_CNT_EN
    int t;
    t = m_cyc;
    return t[CW-1:0];
`else
    return '0;
`endif
  endfunction

  function automatic logic [CW-1:0] exp_ic();
`ifdef MC_PERF_CNT_EN
    int t;
    t = m_ret;
    return t[CW-1:0];
`else
    return '0;
`endif
  endfunction

  // Outputs expected in state p for instruction row k
  function automatic logic [24:0] expect_out(input int k, input logic [2:0] p, input logic rdy,
                                             input logic eq, input logic gtz, input logic rst);
    logic pw, iw, mr, mw, io, rw, src, ill;
    logic [2:0] alu, ext, m2r, npc;
    logic [1:0] dst;
    string nm;
    nm = tbl[k].name;
    {pw, iw, mr, mw, io, rw, src, ill} = 8'd0;
    alu = 3'd0; ext = 3'd0; m2r = 3'd0; npc = 3'd0; dst = 2'd0;
    case (p)
      3'd0: begin mr = 1'b1; pw = rdy & ~rst; iw = rdy & ~rst; end
      3'd1: ill = (nm == "ill") || (nm == "illr");
      3'd2: begin
        alu = tbl[k].alu; src = tbl[k].src; ext = tbl[k].ext;
        if (nm == "beq") begin npc = 3'b001; pw = eq; end
        else if (nm == "bgtz") begin npc = 3'b001; pw = gtz; end
        else if (nm == "bal") begin npc = 3'b001; pw = 1'b1; end
        else if (nm == "j" || nm == "jal") begin npc = 3'b010; pw = 1'b1; end
        else if (nm == "jr" || nm == "jalr") begin npc = 3'b100; pw = 1'b1; end
      end
      3'd3: begin mr = 1'b1; io = 1'b1; end
      3'd4: begin mw = 1'b1; io = 1'b1; end
      3'd5: begin rw = 1'b1; dst = tbl[k].dst; m2r = tbl[k].m2r; end
      default: ;
    endcase
    return {p, pw, iw, mr, mw, io, rw, alu, src, ext, dst, m2r, npc, ill};
  endfunction

  task automatic chk_out(input string tag, input logic [24:0] expv, input logic [24:0] mask);
    logic [24:0] act;
    act = {state, pc_write, ir_write, mem_read, mem_write, iord, reg_write, alu_control,
           alu_src, ext_control, reg_dst, mem2reg, npc_control, illegal};
    checks++;
    if (((act ^ expv) & mask) !== 25'd0) begin
      errors++;
      $display("FAIL %s outputs: got %h want %h (state got %0d want %0d)",
               tag, act & mask, expv & mask, state, expv[24:22]);
    end
    checks++;
    if (cycle_cnt !== exp_cc() || instr_cnt !== exp_ic()) begin
      errors++;
      $display("FAIL %s counters: got cyc=%0d ret=%0d want cyc=%0d ret=%0d",
               tag, cycle_cnt, instr_cnt, exp_cc(), exp_ic());
    end
  endtask

  task automatic get_ready(output bit rdy);
    if (rdy_q.size() > 0) rdy = rdy_q.pop_front();
    else if (rnd) rdy = ($urandom_range(0, 3) != 0);
    else rdy = 1'b1;
  endtask

  // One clock cycle in state p: drive at the falling edge, check just after
  task automatic step(input int k, input logic [2:0] p, input bit rand_cmp, output bit rdy);
    @(negedge clk);
    if (p == 3'd0) begin
      opcode = 6'($urandom);
      funct  = 6'($urandom);
    end else begin
      opcode = tbl[k].op;
      funct  = tbl[k].fn;
    end
    if (rand_cmp) begin
      cmp_eq  = 1'($urandom);
      cmp_gtz = 1'($urandom);
    end else begin
      cmp_eq  = tbl[k].eq;
      cmp_gtz = tbl[k].gtz;
    end
    get_ready(rdy);
    mem_ready = rdy;
    #1;
    chk_out($sformatf("%s/s%0d", tbl[k].name, p),
            expect_out(k, p, rdy, cmp_eq, cmp_gtz, 1'b0),
            (p == 3'd1) ? MASK_DEC : MASK_ALL);
    m_cyc++;
  endtask

  task automatic run_instr(input int k, input bit rand_cmp);
    int pi;
    bit rdy;
    logic [2:0] p;
    pi = 0;
    while (pi < tbl[k].n) begin
      p = tbl[k].seq[3*pi +: 3];
      step(k, p, rand_cmp, rdy);
      if (rdy || !(p == 3'd0 || p == 3'd3 || p == 3'd4)) pi++;
    end
    m_ret++;
  endtask

  initial begin
    int ksw;
    bit rdy;
    logic [9:0] lw_rdy;
    reset = 1'b1; opcode = '0; funct = '0; cmp_eq = 1'b0; cmp_gtz = 1'b0; mem_ready = 1'b1;

    //      name    op         fn         eq gtz alu     src ext     dst    m2r     n  seq
    add_row("add",  6'o00, 6'b100000, 0, 0, 3'd0, 0, 3'd0, 2'b01, 3'd0, 4, Q_ALU);
    add_row("sub",  6'o00, 6'b100010, 0, 0, 3'd1, 0, 3'd0, 2'b01, 3'd0, 4, Q_ALU);
    add_row("xor",  6'o00, 6'b100110, 0, 0, 3'd2, 0, 3'd0, 2'b01, 3'd0, 4, Q_ALU);
    add_row("sll",  6'o00, 6'b000000, 0, 0, 3'd4, 0, 3'd0, 2'b01, 3'd0, 4, Q_ALU);
    add_row("jr",   6'o00, 6'b001000, 0, 0, 3'd0, 0, 3'd0, 2'b00, 3'd0, 3, Q_BR);
    add_row("jalr", 6'o00, 6'b001001, 0, 0, 3'd0, 0, 3'd0, 2'b01, 3'd3, 4, Q_ALU);
    add_row("ori",  6'b001101, 6'd7,  0, 0, 3'd3, 1, 3'd0, 2'b00, 3'd0, 4, Q_ALU);
    add_row("lw",   6'b100011, 6'd9,  0, 0, 3'd0, 1, 3'd1, 2'b00, 3'd1, 5, Q_LD);
    add_row("lb",   6'b100000, 6'd3,  0, 0, 3'd0, 1, 3'd1, 2'b00, 3'd4, 5, Q_LD);
    add_row("sw",   6'b101011, 6'd1,  0, 0, 3'd0, 1, 3'd1, 2'b00, 3'd0, 4, Q_ST);
    add_row("beq",  6'b000100, 6'd0,  0, 1, 3'd0, 0, 3'd0, 2'b00, 3'd0, 3, Q_BR);
    add_row("beq",  6'b000100, 6'd0,  1, 0, 3'd0, 0, 3'd0, 2'b00, 3'd0, 3, Q_BR);
    add_row("bgtz", 6'b000111, 6'd0,  1, 0, 3'd0, 0, 3'd0, 2'b00, 3'd0, 3, Q_BR);
    add_row("bgtz", 6'b000111, 6'd0,  0, 1, 3'd0, 0, 3'd0, 2'b00, 3'd0, 3, Q_BR);
    add_row("addi", 6'b001000, 6'd5,  0, 0, 3'd0, 1, 3'd1, 2'b00, 3'd0, 4, Q_ALU);
    add_row("lui",  6'b001111, 6'd2,  0, 0, 3'd0, 1, 3'd2, 2'b00, 3'd2, 4, Q_ALU);
    add_row("j",    6'b000010, 6'd4,  0, 0, 3'd0, 0, 3'd0, 2'b00, 3'd0, 3, Q_BR);
    add_row("jal",  6'b000011, 6'd4,  0, 0, 3'd0, 0, 3'd0, 2'b10, 3'd3, 4, Q_ALU);
    add_row("bal",  6'b110000, 6'd0,  0, 0, 3'd0, 0, 3'd0, 2'b10, 3'd3, 4, Q_ALU);
    add_row("ill",  6'b111111, 6'd0,  0, 0, 3'd0, 0, 3'd0, 2'b00, 3'd0, 2, Q_ILL);
    add_row("illr", 6'o00, 6'b111111, 0, 0, 3'd0, 0, 3'd0, 2'b00, 3'd0, 2, Q_ILL);

    // Reset state: FETCH with read strobe but no IR/PC load even with memory ready
    @(negedge clk); #1;
    chk_out("reset", expect_out(0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1), MASK_ALL);
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b0; m_cyc = 1;

    // Every table row with zero-wait memory
    for (int k = 0; k < tbl.size(); k++) run_instr(k, 1'b0);

    // lw: two wait cycles in FETCH and three in MEM_RD -> ten cycles
    lw_rdy = 10'b1100011100;
    for (int i = 0; i < 10; i++) rdy_q.push_back(lw_rdy[i]);
    run_instr(find("lw"), 1'b0);

    // Reset asserted while sw is stalled in MEM_WR
    ksw = find("sw");
    rdy_q.push_back(1'b1); rdy_q.push_back(1'b1); rdy_q.push_back(1'b1); rdy_q.push_back(1'b0);
    step(ksw, 3'd0, 1'b0, rdy);
    step(ksw, 3'd1, 1'b0, rdy);
    step(ksw, 3'd2, 1'b0, rdy);
    step(ksw, 3'd4, 1'b0, rdy);
    #2;
    reset = 1'b1;
    m_cyc = 0; m_ret = 0;
    #1;
    chk_out("rst_mid_memwr", expect_out(ksw, 3'd0, 1'b0, cmp_eq, cmp_gtz, 1'b1), MASK_ALL);
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    chk_out("rst_hold", expect_out(ksw, 3'd0, 1'b1, cmp_eq, cmp_gtz, 1'b1), MASK_ALL);
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b0; m_cyc = 1;
    for (int i = 0; i < 16; i++) begin
      rdy_q.push_back(1'b0);
      step(0, 3'd0, 1'b0, rdy);
    end
    @(posedge clk); #1;
    checks++;
    if (cycle_cnt !== WRAP_EXP) begin
      errors++;
      $display("FAIL cnt_wrap: cycle_cnt got %0d want %0d", cycle_cnt, WRAP_EXP);
    end

    // Randomized instruction stream with random memory waits and compare flags
    rnd = 1'b1;
    repeat (150) run_instr($urandom_range(0, tbl.size() - 1), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit for the MIPS-subset core. It replaces single-cycle decode with a state machine that sequences one shared datapath through fetch, decode, execute, memory and write-back. The datapath holds the ALU, one unified memory port, IR, PC and the A/B/ALUOut/MDR latches. Per instruction, the unit issues datapath strobes and mux selects, and stalls on a memory-ready handshake.

## Interface
- CNT_W, 32, width of performance counters
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- opcode  in  6  IR[31:26], stable from DECODE through end of instruction
- funct  in  6  IR[5:0]
- cmp_eq  in  1  datapath rs==rt
- cmp_gtz  in  1  datapath signed rs>0
- mem_ready  in  1  memory completes current access this cycle
- pc_write  out  1  load PC from NPC
- ir_write  out  1  load IR from memory read data
- mem_read, mem_write  out  1  memory strobes
- iord  out  1  0: address=PC, 1: address=ALUOut
- reg_write  out  1  GRF write enable
- alu_control  out  3  000 add, 001 sub, 010 xor, 011 or, 100 sll
- alu_src  out  1  0: B, 1: extended imm
- ext_control  out  3  000 zero, 001 sign, 010 lui
- reg_dst  out  2  00 rt, 01 rd, 10 $31
- mem2reg  out  3  000 ALUOut, 001 word MDR, 010 lui, 011 PC+4 link, 100 byte MDR
- npc_control  out  3  000 PC+4, 001 branch, 010 j/jal, 100 jr/jalr
- illegal  out  1  one-cycle pulse on unrecognised instruction
- state  out  3  current state
- cycle_cnt, instr_cnt  out  CNT_W  performance counters

## Operation
- Recognised instructions: add, sub, xor, sll, jr, jalr, ori, lw, lb, sw, beq, bgtz, addi, lui, j, jal, bal (opcode 110000).
- Default strobe value is 0. Default value for selects is 000/00/0 unless listed below.
- States: FETCH=0, DECODE=1, EXEC=2, MEM_RD=3, MEM_WR=4, WB=5. Codes 6–7 go to FETCH next cycle, with all strobes 0.
- FETCH
  - mem_read=1, iord=0, npc_control=000.
  - ir_write=pc_write=mem_ready.
  - Advance to DECODE only when mem_ready=1; otherwise hold.
- DECODE
  - Datapath latches A/B. ext_control is driven from the decode.
  - Unrecognised instruction: illegal=1, next state FETCH; counts as retired.
  - Otherwise next state EXEC.
- EXEC
  - ALU ops: alu_control/alu_src/ext_control per instruction, next state WB.
  - lw/lb/sw: alu add, alu_src=1, ext sign. lw/lb go to MEM_RD, sw goes to MEM_WR.
  - beq: npc_control=001, pc_write=cmp_eq. bgtz: same with cmp_gtz. Both then go to FETCH.
  - bal: npc_control=001, pc_write=1, next state WB.
  - j: npc_control=010, pc_write=1, next state FETCH. jal: same but next state WB.
  - jr: npc_control=100, pc_write=1, next state FETCH. jalr: same but next state WB.
- MEM_RD: mem_read=1, iord=1. Hold until mem_ready, then WB.
- MEM_WR: mem_write=1, iord=1. Hold until mem_ready, then FETCH.
- WB: reg_write=1, reg_dst and mem2reg per instruction, next state FETCH.
  - reg_dst: R-type 01, jal/bal 10, others 00.
  - mem2reg: lw 001, lui 010, jal/jalr/bal 011, lb 100, else 000.
- A strobe asserted during a stall is held for the whole stall; mem_write stays high until mem_ready.

## Timing
- Outputs are combinational from the state register and opcode/funct. The state register is the only sequential element besides the counters.
- Reset asynchronously forces state=FETCH and counters=0.
  - While reset is high: mem_read=1, iord=0. ir_write=pc_write=0 regardless of mem_ready. All other outputs 0.
- Reset mid-instruction abandons it; no write strobes are issued after reset asserts.
- Cycles per instruction with zero-wait memory:
  - branch, j, jr: 3
  - jal, jalr, bal, ALU ops, sw: 4
  - lw, lb: 5
- Each mem_ready=0 cycle adds one cycle.
- An instruction retires on the clock edge where the next state becomes FETCH from DECODE, EXEC, MEM_WR or WB.

## Configuration
- MC_PERF_CNT_EN defined:
  - cycle_cnt increments every cycle out of reset.
  - instr_cnt increments on each retirement.
  - Both wrap modulo 2^CNT_W.
- Undefined: cycle_cnt and instr_cnt are tied to 0 and no counter flops are built. FSM behaviour is identical.

## Test plan
- add $3,$1,$2, mem_ready=1 → states 0,1,2,5,0; reg_write=1 only in cycle 4 with reg_dst=01; instr_cnt 0→1.
- lw, mem_ready low 2 cycles in FETCH and 3 cycles in MEM_RD → total 10 cycles; mem_read held high; reg_write once with mem2reg=001.
- beq with cmp_eq=0 then 1 → pc_write in EXEC is 0 then 1, npc_control=001; 3 cycles each.
- jal → EXEC pc_write=1, npc_control=010; WB reg_dst=10, mem2reg=011.
- Opcode 111111 → illegal pulses 1 cycle in DECODE, back in FETCH; no reg_write or mem_write.
- Reset asserted mid-MEM_WR → mem_write drops immediately, state=0, counters 0. With MC_PERF_CNT_EN and CNT_W=4, 17 cycles after reset → cycle_cnt=1.
